// File: rtl/ssd_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: shadowed digit data,
// per-digit enable/dp, leading-zero blanking and per-slot PWM brightness.
module ssd_scan_driver #(
  parameter int NUM_DIGITS    = 8,
  parameter int SCAN_DIV_BITS = 18,
  parameter int BRIGHT_BITS   = 4,
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              cathodes,
  output logic [IDX_W-1:0]        scan_idx
);

  logic [SCAN_DIV_BITS-1:0] dwell_q, dwell_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [BRIGHT_BITS-1:0]   bright_q, bright_eff;
  logic [4*NUM_DIGITS-1:0]  sh_dig_q;
  logic [NUM_DIGITS-1:0]    sh_dp_q, sh_en_q;
  logic [NUM_DIGITS-1:0]    an_q, an_d;
  logic [7:0]               cath_q, cath_d;
  logic [3:0]               nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]    lz_mask;
  logic                     all_zero;
  logic                     seg_on;
  logic                     blank;
  logic [6:0]               seg;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign nib[gi] = sh_dig_q[4*gi +: 4];
    end
  endgenerate

  // Digit i is a leading zero when it and every digit above it are zero;
  // digit 0 is never blanked so a zero value still shows "0".
  always_comb begin
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero & (nib[i] == 4'h0);
      lz_mask[i] = blank_lz & all_zero;
    end
  end

  always_comb begin
    seg = 7'b1111111;
    case (nib[idx_q])
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
  end

  // At count 0 the incoming brightness already governs this slot, so a whole
  // slot always runs at a single duty value.
  always_comb begin
    bright_eff = (dwell_q == '0) ? brightness : bright_q;
    seg_on     = dwell_q[SCAN_DIV_BITS-1 -: BRIGHT_BITS] < bright_eff;
    blank      = ~sh_en_q[idx_q] | ~seg_on | lz_mask[idx_q];

    dwell_d = dwell_q + SCAN_DIV_BITS'(1);
    idx_d   = idx_q;
    if (dwell_q == '1) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    an_d   = '1;
    cath_d = 8'hFF;
    if (!blank) begin
      an_d   = ~(NUM_DIGITS'(1) << idx_q);
      cath_d = {seg, ~sh_dp_q[idx_q]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q  <= '0;
      idx_q    <= '0;
      bright_q <= '0;
      sh_dig_q <= '0;
      sh_dp_q  <= '0;
      sh_en_q  <= '0;
      an_q     <= '1;
      cath_q   <= 8'hFF;
    end else begin
      dwell_q  <= dwell_d;
      idx_q    <= idx_d;
      bright_q <= bright_eff;
      if (load) begin
        sh_dig_q <= digits;
        sh_dp_q  <= dp_in;
        sh_en_q  <= digit_en;
      end
      an_q     <= an_d;
      cath_q   <= cath_d;
    end
  end

  assign an       = an_q;
  assign cathodes = cath_q;
  assign scan_idx = idx_q;

endmodule
